// File: rtl/prio_slot_pkg.sv
// Shared constants, op-codes, FSM state type and slot format for the priority slot writer.
// No logic of its own; purely declarations used by the slot writer and its search sub-module.
// No flow control here; handshake behaviour lives in prio_slot_writer.
package prio_slot_pkg;

  localparam int NUM_SLOTS = 6;
  localparam int SLOT_W    = 8;
  localparam int ID_W      = 4;
  localparam int PRIO_W    = 4;
  localparam int IDX_W     = 3;
  localparam logic [PRIO_W-1:0] PRIO_MAX = 4'd15;

  typedef enum logic [1:0] {
    OP_INSERT = 2'b00,
    OP_UPDATE = 2'b01,
    OP_REMOVE = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [PRIO_W-1:0] prio;
    logic [ID_W-1:0]   id;
  } slot_t;

  // Priority increment that sticks at PRIO_MAX.
  function automatic logic [PRIO_W-1:0] prio_sat_inc(input logic [PRIO_W-1:0] p);
    return (p == PRIO_MAX) ? p : p + 4'd1;
  endfunction

endpackage

// File: rtl/prio_slot_writer_if.sv
// Request, retire and slot-table status signals of the priority slot writer.
// Pure wiring, no latency.
// req_valid/req_ready handshake; done strobe and status outputs have no backpressure.
interface prio_slot_writer_if;
  import prio_slot_pkg::*;

  logic                        req_valid;
  logic                        req_ready;
  logic [1:0]                  req_op;
  logic [ID_W-1:0]             req_id;
  logic [PRIO_W-1:0]           req_prio;
  logic                        done_valid;
  logic [ID_W-1:0]             done_id;
  logic [NUM_SLOTS*SLOT_W-1:0] slot_bus;
  logic [2:0]                  count;
  logic                        full;
  logic                        err;

  modport master (
    output req_valid, req_op, req_id, req_prio, done_valid, done_id,
    input  req_ready, slot_bus, count, full, err
  );

  modport slave (
    input  req_valid, req_op, req_id, req_prio, done_valid, done_id,
    output req_ready, slot_bus, count, full, err
  );

endinterface

// File: rtl/slot_match.sv
// Finds the slot holding a given id and the lowest-index empty slot.
// Purely combinational, zero latency.
// No handshake; results are sampled by the caller when it needs them.
module slot_match
  import prio_slot_pkg::*;
(
  input  logic [NUM_SLOTS*SLOT_W-1:0] slots_i,
  input  logic [ID_W-1:0]             id_i,
  output logic                        match_vld_o,
  output logic [IDX_W-1:0]            match_idx_o,
  output logic                        free_vld_o,
  output logic [IDX_W-1:0]            free_idx_o
);

  // Scan high to low so the lowest matching / free index wins.
  always_comb begin
    match_vld_o = 1'b0;
    match_idx_o = '0;
    free_vld_o  = 1'b0;
    free_idx_o  = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (id_i != '0 && slots_i[k*SLOT_W +: ID_W] == id_i) begin
        match_vld_o = 1'b1;
        match_idx_o = IDX_W'(k);
      end
      if (slots_i[k*SLOT_W +: SLOT_W] == '0) begin
        free_vld_o = 1'b1;
        free_idx_o = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/prio_slot_writer.sv
// Six-entry {prio,id} slot table with insert/update/remove requests and retire clears; optional aging (PRIO_AGING_EN).
// Accept-to-visible latency 3 cycles (IDLE accept, SEARCH, COMMIT); err pulses the cycle after a rejected COMMIT.
// req_ready only in IDLE, so one request in flight; done_valid is never backpressured and acts in any state.
module prio_slot_writer
  import prio_slot_pkg::*;
#(
  parameter int AGE_PERIOD = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  prio_slot_writer_if.slave   bus
);

  if (AGE_PERIOD < 2 || AGE_PERIOD > 65535) begin : g_bad_age_period
    $error("AGE_PERIOD must be in 2..65535");
  end

  state_e                      state_q, state_d;
  op_e                         op_q;
  logic [ID_W-1:0]             id_q;
  logic [PRIO_W-1:0]           prio_q;
  logic                        match_vld_q, free_vld_q;
  logic [IDX_W-1:0]            match_idx_q, free_idx_q;
  logic                        srch_match_vld, srch_free_vld;
  logic [IDX_W-1:0]            srch_match_idx, srch_free_idx;
  logic [SLOT_W-1:0]           slot_q [NUM_SLOTS];
  logic [SLOT_W-1:0]           slot_d [NUM_SLOTS];
  logic [NUM_SLOTS*SLOT_W-1:0] slots_flat;
  logic [NUM_SLOTS-1:0]        done_hit;
  logic                        ready, accept;
  logic                        wr_en, reject, tgt_live;
  logic [IDX_W-1:0]            wr_idx;
  logic [SLOT_W-1:0]           wr_val;
  logic                        err_q;
  logic [2:0]                  cnt;
  logic                        age_tick;

  assign ready  = (state_q == ST_IDLE);
  assign accept = bus.req_valid && ready;

  // Flatten the slot registers onto the sorter-facing bus.
  always_comb begin
    slots_flat = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slots_flat[k*SLOT_W +: SLOT_W] = slot_q[k];
    end
  end

  slot_match u_slot_match (
    .slots_i     (slots_flat),
    .id_i        (id_q),
    .match_vld_o (srch_match_vld),
    .match_idx_o (srch_match_idx),
    .free_vld_o  (srch_free_vld),
    .free_idx_o  (srch_free_idx)
  );

  // Retire strobe hits whichever occupied slot carries done_id; id 0 never matches.
  always_comb begin
    done_hit = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      done_hit[k] = bus.done_valid && (bus.done_id != '0) &&
                    (slot_q[k][ID_W-1:0] == bus.done_id);
    end
  end

`ifdef PRIO_AGING_EN
  logic [15:0] age_cnt_q;

  assign age_tick = (age_cnt_q == 16'(AGE_PERIOD - 1));

  // Free-running aging period counter, restarted from zero by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) age_cnt_q <= '0;
    else        age_cnt_q <= age_tick ? '0 : age_cnt_q + 16'd1;
  end
`else
  assign age_tick = 1'b0;
`endif

  // FSM next state: one request walks IDLE -> SEARCH -> COMMIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SEARCH;
      ST_SEARCH: state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture the request on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_INSERT;
      id_q   <= '0;
      prio_q <= '0;
    end else if (accept) begin
      op_q   <= op_e'(bus.req_op);
      id_q   <= bus.req_id;
      prio_q <= bus.req_prio;
    end
  end

  // Register the search result so COMMIT works from a stable snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
    end else if (state_q == ST_SEARCH) begin
      match_vld_q <= srch_match_vld;
      match_idx_q <= srch_match_idx;
      free_vld_q  <= srch_free_vld;
      free_idx_q  <= srch_free_idx;
    end
  end

  // COMMIT decode: choose the slot write or reject. An update whose target
  // was retired since SEARCH (or is retired this cycle) is dropped with err;
  // a remove of a target already gone is harmless and not an error.
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = free_idx_q;
    wr_val   = {prio_q, id_q};
    reject   = 1'b0;
    tgt_live = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (match_idx_q == IDX_W'(k) && slot_q[k][ID_W-1:0] == id_q && !done_hit[k]) begin
        tgt_live = 1'b1;
      end
    end
    if (state_q == ST_COMMIT) begin
      case (op_q)
        OP_INSERT: begin
          if (!free_vld_q || match_vld_q || id_q == '0 || prio_q == '0) begin
            reject = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wr_idx = free_idx_q;
          end
        end
        OP_UPDATE: begin
          if (!match_vld_q || prio_q == '0 || !tgt_live) begin
            reject = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wr_idx = match_idx_q;
          end
        end
        OP_REMOVE: begin
          if (!match_vld_q) begin
            reject = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wr_idx = match_idx_q;
            wr_val = '0;
          end
        end
        default: reject = 1'b1;
      endcase
    end
  end

  // Slot next value: retire clear beats COMMIT write beats aging beats hold.
  always_comb begin
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slot_d[k] = slot_q[k];
      if (age_tick && slot_q[k] != '0) begin
        slot_d[k] = {prio_sat_inc(slot_q[k][SLOT_W-1:ID_W]), slot_q[k][ID_W-1:0]};
      end
      if (wr_en && wr_idx == IDX_W'(k)) slot_d[k] = wr_val;
      if (done_hit[k])                  slot_d[k] = '0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SLOTS; k++) slot_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) slot_q[k] <= slot_d[k];
    end
  end

  // Error pulse for the cycle following a rejected COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= reject;
  end

  // Occupancy straight from the slot registers.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_q[k] != '0) cnt = cnt + 3'd1;
    end
  end

  assign bus.req_ready = ready;
  assign bus.slot_bus  = slots_flat;
  assign bus.count     = cnt;
  assign bus.full      = (cnt == 3'(NUM_SLOTS));
  assign bus.err       = err_q;

endmodule

// File: doc/prio_slot_writer.md
PRIO_SLOT_WRITER -- requirements
Module: prio_slot_writer

Interface
REQ-001 SHALL have parameter: AGE_PERIOD, default 64, cycles between aging ticks (range 2..65535).
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  in  1  request present.
REQ-005 SHALL have port: req_ready  out  1  block can accept a request.
REQ-006 SHALL have port: req_op  in  2  00 insert, 01 update priority, 10 remove, 11 reserved.
REQ-007 SHALL have port: req_id  in  4  task id, 1..15.
REQ-008 SHALL have port: req_prio  in  4  priority, 1..15.
REQ-009 SHALL have port: done_valid  in  1  one-cycle retire strobe from the dispatcher.
REQ-010 SHALL have port: done_id  in  4  id of the retired task.
REQ-011 SHALL have port: slot_bus  out  48  slot k at bits [8k+7:8k], format {prio[3:0], id[3:0]}, feeds the max-sorter inputs a1..a6.
REQ-012 SHALL have port: count  out  3  number of occupied slots, 0..6.
REQ-013 SHALL have port: full  out  1  count == 6.
REQ-014 SHALL have port: err  out  1  one-cycle pulse on a rejected request.

Function
REQ-015 SHALL treat a slot byte of 0x00 as empty; an occupied slot always has prio != 0 and id != 0.
REQ-016 SHALL implement the FSM IDLE -> SEARCH -> COMMIT -> IDLE; req_ready SHALL be 1 only in IDLE.
REQ-017 SHALL register req_op, req_id and req_prio on the cycle where req_valid && req_ready, then enter SEARCH.
REQ-018 SHALL, in SEARCH, register the matching-id slot index (or none) and the lowest-index empty slot (or none).
REQ-019 SHALL, in COMMIT, apply the operation; slot_bus reflects it at the clock edge ending COMMIT, so accept-to-visible latency is 3 cycles.
REQ-020 SHALL, for insert, write {prio, id} into the lowest empty slot; it SHALL reject (err, no write) if the table is full, the id is already present, or id/prio is 0.
REQ-021 SHALL, for update, overwrite the prio of the matching slot; it SHALL reject if no slot matches or prio is 0.
REQ-022 SHALL, for remove, clear the matching slot to 0x00; it SHALL reject if no slot matches.
REQ-023 SHALL treat op 11 as a rejected request (err pulse, no state change).
REQ-024 SHALL clear a slot matching done_id on the same clock edge in any FSM state; done_id of 0 or with no match SHALL be ignored without err.
REQ-025 SHALL resolve a done and a COMMIT on the same slot in the same cycle as follows: remove -> slot cleared, no err; update -> slot cleared, update dropped, err pulses.
REQ-026 SHALL, for an insert, use the empty slot found in SEARCH even if a done frees a lower slot during COMMIT.
REQ-027 SHALL update count and full combinationally from the slot registers.
REQ-028 SHALL drive err high for exactly the cycle following the COMMIT of a rejected request.

Reset
REQ-029 SHALL, while rst_n = 0, force slot_bus = 0, count = 0, full = 0, err = 0, FSM = IDLE, and aging counter = 0.
REQ-030 SHALL, on reset asserted mid-operation, discard any pending request with no err pulse; req_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-031 SHALL, when PRIO_AGING_EN is defined, increment every occupied slot's prio by 1 (saturating at 15) once every AGE_PERIOD cycles, counted from reset release.
REQ-032 SHALL, when an aging tick and a COMMIT write hit the same slot in the same cycle, keep the COMMIT value; a done on that slot SHALL still clear it.
REQ-033 SHALL, when PRIO_AGING_EN is undefined, contain no aging counter and leave priorities unchanged except by requests.

Structure
REQ-034 SHALL take NUM_SLOTS = 6, SLOT_W = 8, PRIO_MAX = 15, the op-code constants and the FSM state type from shared package prio_slot_pkg.
REQ-035 SHALL place the id-match and first-free search in one combinational sub-module, slot_match.

Verification
REQ-036 SHALL cover: insert id 3 prio 5 into an empty table -> slot0 = 0x53 three cycles after accept, count = 1.
REQ-037 SHALL cover: 6 inserts (ids 1..6), then insert id 7 -> err pulses once, full = 1, slot_bus unchanged.
REQ-038 SHALL cover: insert id 2 twice -> second request raises err and the table holds a single id 2.
REQ-039 SHALL cover: update id 4 to prio 9 with done_id = 4 strobed in COMMIT -> slot cleared and err pulses.
REQ-040 SHALL cover: with PRIO_AGING_EN and AGE_PERIOD = 4, slot 0xE1 -> 0xF1 after one tick and remains 0xF1 after later ticks.
REQ-041 SHALL cover: rst_n asserted during SEARCH -> all outputs 0 and req_ready = 1 in the first cycle after release.
